delta_dist_calc: RTL and testbench

Request-side client of the raycaster's sequential fixed-point divider. For each ray it accepts a signed ray direction (dir_x, dir_y), issues two divisions 1.0/dir_x and 1.0/dir_y through the divider's start/busy/done handshake, and presents |1/dir| per axis (DDA delta distance) on a valid/ready output. Divide-by-zero, overflow and a lost handshake all saturate the result so the DDA stepper never stalls. It sits between the ray generator and the DDA stepper; one divider instance is shared serially for both axes.

---
 rtl/delta_dist_calc.sv | 167 ++++++++++++++++
 tb/tb_delta_dist_calc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_dist_calc.sv
// delta_dist_calc: turns a ray direction into per-axis DDA delta distances
// |1/dir_x| and |1/dir_y| using one shared sequential divider. Any division
// that cannot produce a usable quotient (divide by zero, overflow, invalid
// result or a divider that never answers) yields the saturated maximum, so
// the downstream stepper always receives a result.
module delta_dist_calc #(
  parameter int WIDTH   = 16,
  parameter int FBITS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ray_valid_in,
  output logic                    ray_ready_out,
  input  logic signed [WIDTH-1:0] ray_dir_x_in,
  input  logic signed [WIDTH-1:0] ray_dir_y_in,
  output logic                    div_start_out,
  output logic signed [WIDTH-1:0] div_a_out,
  output logic signed [WIDTH-1:0] div_b_out,
  input  logic                    div_busy_in,
  input  logic                    div_done_in,
  input  logic                    div_valid_in,
  input  logic                    div_dbz_in,
  input  logic                    div_ovf_in,
  input  logic signed [WIDTH-1:0] div_val_in,
  output logic [WIDTH-1:0]        delta_x_out,
  output logic [WIDTH-1:0]        delta_y_out,
  output logic [1:0]              sat_out,
  output logic                    delta_valid_out,
  input  logic                    delta_ready_in
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_X  = 3'd1;
  localparam logic [2:0] S_WAIT_X = 3'd2;
  localparam logic [2:0] S_REQ_Y  = 3'd3;
  localparam logic [2:0] S_WAIT_Y = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FBITS;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0]    WD_LAST = CW'(TIMEOUT - 1);

  logic [2:0]              state_q, state_d;
  logic signed [WIDTH-1:0] dirX_q, dirX_d;
  logic signed [WIDTH-1:0] dirY_q, dirY_d;
  logic [WIDTH-1:0]        deltaX_q, deltaX_d;
  logic [WIDTH-1:0]        deltaY_q, deltaY_d;
  logic [1:0]              sat_q, sat_d;
  logic [CW-1:0]           wdog_q, wdog_d;

  logic             inReq;
  logic             startOk;
  logic             timedOut;
  logic             axisDone;
  logic             axisSat;
  logic [WIDTH-1:0] absVal;
  logic [WIDTH-1:0] axisResult;

  // Start is only legal when the divider is idle and not still showing a
  // stale done; the same condition moves the FSM into its WAIT state.
  // A WAIT state that outlives TIMEOUT cycles is treated as a failed
  // division. A missing done, a flagged error or an invalid quotient all
  // saturate; otherwise the quotient magnitude is used (0x8000 never
  // arrives here because the divider reports it as overflow).
  always_comb begin
    inReq      = (state_q == S_REQ_X) || (state_q == S_REQ_Y);
    startOk    = inReq && !div_busy_in && !div_done_in;
    timedOut   = (wdog_q == WD_LAST);
    axisDone   = div_done_in || timedOut;
    axisSat    = !div_done_in || div_dbz_in || div_ovf_in || !div_valid_in;
    absVal     = div_val_in[WIDTH-1] ? -div_val_in : div_val_in;
    axisResult = axisSat ? SAT_MAX : absVal;
  end

  // Next-state logic: accept a ray, divide X then Y, then hold the result
  // until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    dirX_d   = dirX_q;
    dirY_d   = dirY_q;
    deltaX_d = deltaX_q;
    deltaY_d = deltaY_q;
    sat_d    = sat_q;
    wdog_d   = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (ray_valid_in) begin
          dirX_d  = ray_dir_x_in;
          dirY_d  = ray_dir_y_in;
          sat_d   = 2'b00;
          state_d = S_REQ_X;
        end
      end
      S_REQ_X: begin
        if (startOk) begin
          wdog_d  = '0;
          state_d = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        wdog_d = wdog_q + CW'(1);
        if (axisDone) begin
          deltaX_d = axisResult;
          sat_d[0] = axisSat;
          state_d  = S_REQ_Y;
        end
      end
      S_REQ_Y: begin
        if (startOk) begin
          wdog_d  = '0;
          state_d = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        wdog_d = wdog_q + CW'(1);
        if (axisDone) begin
          deltaY_d = axisResult;
          sat_d[1] = axisSat;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (delta_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any ray in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      dirX_q   <= '0;
      dirY_q   <= '0;
      deltaX_q <= '0;
      deltaY_q <= '0;
      sat_q    <= 2'b00;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      dirX_q   <= dirX_d;
      dirY_q   <= dirY_d;
      deltaX_q <= deltaX_d;
      deltaY_q <= deltaY_d;
      sat_q    <= sat_d;
      wdog_q   <= wdog_d;
    end
  end

  // Outputs are forced low while reset is asserted so nothing is accepted
  // or started during the reset cycle itself.
  always_comb begin
    ray_ready_out   = (state_q == S_IDLE) && !rst_in;
    div_start_out   = startOk && !rst_in;
    delta_valid_out = (state_q == S_OUT) && !rst_in;
    div_a_out       = ONE;
    div_b_out       = ((state_q == S_REQ_Y) || (state_q == S_WAIT_Y)) ? dirY_q : dirX_q;
    delta_x_out     = rst_in ? '0 : deltaX_q;
    delta_y_out     = rst_in ? '0 : deltaY_q;
    sat_out         = rst_in ? 2'b00 : sat_q;
  end

endmodule

// File: tb/tb_delta_dist_calc.sv
// Testbench for delta_dist_calc: a behavioural divider drives the divider
// handshake, and each ray's result, saturation bits and latency are compared
// against expectations computed from plain integer arithmetic.
module tb_delta_dist_calc;

   localparam int WIDTH   = 16;
   localparam int FBITS   = 8;
   localparam int TIMEOUT = 64;
   localparam int ITER    = WIDTH - 1 + FBITS;

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               ray_valid_in;
   logic               ray_ready_out;
   logic signed [15:0] ray_dir_x_in;
   logic signed [15:0] ray_dir_y_in;
   logic               div_start_out;
   logic signed [15:0] div_a_out;
   logic signed [15:0] div_b_out;
   logic               div_busy_in = 1'b0;
   logic               div_done_in = 1'b0;
   logic               div_valid_in = 1'b0;
   logic               div_dbz_in = 1'b0;
   logic               div_ovf_in = 1'b0;
   logic signed [15:0] div_val_in = '0;
   logic [15:0]        delta_x_out;
   logic [15:0]        delta_y_out;
   logic [1:0]         sat_out;
   logic               delta_valid_out;
   logic               delta_ready_in;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;
   // 0: normal divider, 1: divider never answers, 2: busy held 5 cycles at ray start
   int mode        = 0;
   int busyFrom    = -100;
   int doneAt      = -1;
   int startCyc    = -1;
   int startCount  = 0;
   bit prevStart   = 1'b0;
   int dA, dB, dQ;
   bit early;
   logic        resValid, resDbz, resOvf;
   logic [15:0] resVal;

   delta_dist_calc #(.WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT(TIMEOUT)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .ray_valid_in(ray_valid_in), .ray_ready_out(ray_ready_out),
      .ray_dir_x_in(ray_dir_x_in), .ray_dir_y_in(ray_dir_y_in),
      .div_start_out(div_start_out), .div_a_out(div_a_out), .div_b_out(div_b_out),
      .div_busy_in(div_busy_in), .div_done_in(div_done_in), .div_valid_in(div_valid_in),
      .div_dbz_in(div_dbz_in), .div_ovf_in(div_ovf_in), .div_val_in(div_val_in),
      .delta_x_out(delta_x_out), .delta_y_out(delta_y_out), .sat_out(sat_out),
      .delta_valid_out(delta_valid_out), .delta_ready_in(delta_ready_in)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expected |1/d| in fixed point, saturating when no finite in-range value exists.
   task automatic refDelta(input logic [15:0] d, output logic [15:0] mag, output bit sat);
      int di, q;
      di = int'($signed(d));
      q = 0;
      if (di == 0 || di == -32768) sat = 1'b1;
      else begin
         q = 65536 / di;
         sat = (q > 32767) || (q < -32767);
      end
      mag = sat ? 16'h7FFF : 16'((q < 0) ? -q : q);
   endtask

   // Divider side, start capture: latch the operands on the edge a start is
   // accepted and schedule done, checking the start handshake rules.
   always @(posedge clk_in) begin
      if (rst_in) begin
         doneAt    = -1;
         prevStart = 1'b0;
      end else begin
         if (div_start_out) begin
            startCount++;
            checkOutput("start_protocol", {62'b0, div_busy_in, prevStart}, 64'd0);
            dA = int'(div_a_out);
            dB = int'(div_b_out);
            resDbz = 1'b0; resOvf = 1'b0; resValid = 1'b0; resVal = '0; early = 1'b1;
            if (dB == 0) resDbz = 1'b1;
            else if (dB == -32768) resOvf = 1'b1;
            else begin
               dQ = (dA * (1 << FBITS)) / dB;
               if (dQ > 32767 || dQ < -32767) resOvf = 1'b1;
               else begin
                  resValid = 1'b1;
                  resVal   = 16'(dQ);
                  early    = 1'b0;
               end
            end
            startCyc = cyc;
            doneAt   = (mode == 1) ? -1 : cyc + (early ? 1 : ITER + 4);
         end
         prevStart = div_start_out;
      end
      cyc++;
   end

   // Divider side, status outputs: updated mid-cycle so the DUT sees them at the next edge.
   always @(negedge clk_in) begin
      div_done_in  = (doneAt >= 0) && (cyc == doneAt);
      div_busy_in  = ((doneAt >= 0) && (cyc > startCyc) && (cyc < doneAt)) ||
                     ((mode == 2) && (cyc >= busyFrom) && (cyc < busyFrom + 5));
      div_valid_in = div_done_in && resValid;
      div_dbz_in   = div_done_in && resDbz;
      div_ovf_in   = div_done_in && resOvf;
      div_val_in   = div_done_in ? resVal : '0;
   end

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   // Offer one ray, wait for its result, hold backpressure for 'stall' cycles, then release.
   task automatic applyStimulus(input logic [15:0] dx, input logic [15:0] dy, input int stall);
      logic [15:0] ex, ey;
      bit sx, sy;
      int lx, ly, lat, acc, s0;
      logic [35:0] expVec;
      refDelta(dx, ex, sx);
      refDelta(dy, ey, sy);
      if (mode == 1) begin
         ex = 16'h7FFF; ey = 16'h7FFF; sx = 1'b1; sy = 1'b1;
         lx = TIMEOUT; ly = TIMEOUT;
      end else begin
         lx = sx ? 1 : ITER + 4;
         ly = sy ? 1 : ITER + 4;
      end
      lat = 3 + lx + ly + ((mode == 2) ? 5 : 0);

      tick();
      checkOutput("ray_ready_idle", ray_ready_out, 1);
      ray_dir_x_in = dx;
      ray_dir_y_in = dy;
      ray_valid_in = 1'b1;
      acc = cyc;
      s0  = startCount;
      if (mode == 2) busyFrom = cyc + 1;
      tick();
      ray_valid_in = 1'b0;
      while (!delta_valid_out && (cyc - acc) < 400) tick();
      checkOutput("valid_seen", delta_valid_out, 1);
      checkOutput("latency", cyc - acc, lat);
      checkOutput("delta_x", delta_x_out, ex);
      checkOutput("delta_y", delta_y_out, ey);
      checkOutput("sat", sat_out, {sy, sx});
      checkOutput("start_pulses", startCount - s0, 2);
      expVec = {1'b1, 1'b0, sy, sx, ex, ey};
      for (int i = 0; i < stall; i++) begin
         tick();
         checkOutput("stall_hold", {delta_valid_out, ray_ready_out, sat_out, delta_x_out, delta_y_out}, expVec);
         checkOutput("stall_no_start", startCount - s0, 2);
      end
      delta_ready_in = 1'b1;
      tick();
      delta_ready_in = 1'b0;
      checkOutput("release_idle", {ray_ready_out, delta_valid_out}, 2'b10);
   endtask

   function automatic logic [15:0] pickDir();
      logic [15:0] v;
      if ($urandom_range(0, 3) == 0) begin
         v = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) v = -v;
      end else begin
         v = 16'($urandom);
      end
      return v;
   endfunction

   // Directed sequence followed by randomized rays.
   initial begin
      rst_in = 1'b1;
      ray_valid_in = 1'b0;
      ray_dir_x_in = '0;
      ray_dir_y_in = '0;
      delta_ready_in = 1'b0;
      tick();
      checkOutput("reset_ray_ready", ray_ready_out, 0);
      checkOutput("reset_start", div_start_out, 0);
      tick();
      rst_in = 1'b0;
      tick();
      checkOutput("after_reset", {ray_ready_out, delta_valid_out, div_start_out, sat_out, delta_x_out, delta_y_out},
                  {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000});

      $display("[TB] directed rays");
      applyStimulus(16'h0100, 16'h0200, 0);
      applyStimulus(16'hFF80, 16'h0400, 0);
      applyStimulus(16'h0000, 16'h0100, 0);
      applyStimulus(16'h8000, 16'h0001, 0);
      applyStimulus(16'h0100, 16'h0200, 10);

      $display("[TB] divider that never answers");
      mode = 1;
      applyStimulus(16'h0100, 16'h0100, 0);
      $display("[TB] divider busy at ray start");
      mode = 2;
      applyStimulus(16'h0200, 16'hFF00, 0);
      mode = 0;

      $display("[TB] reset during division");
      tick();
      ray_dir_x_in = 16'h0300;
      ray_dir_y_in = 16'hFD00;
      ray_valid_in = 1'b1;
      tick();
      ray_valid_in = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst_in = 1'b1;
      tick();
      checkOutput("midreset_outputs", {ray_ready_out, div_start_out, delta_valid_out}, 3'b000);
      rst_in = 1'b0;
      tick();
      checkOutput("post_midreset", {ray_ready_out, delta_valid_out, div_start_out, sat_out, delta_x_out, delta_y_out},
                  {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000});
      applyStimulus(16'h0300, 16'hFD00, 0);

      $display("[TB] random rays");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(pickDir(), pickDir(), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Guard against a hung simulation.
   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, failures so far %0d", failCount);
      $fatal(1, "[TB] timeout");
   end

endmodule
